// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared MIPS definitions for the instruction fetch stage: the NOP
//   encoding, the default reset PC, the fetch FSM state encoding and a
//   small word-alignment helper.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    // sll $0,$0,0 -- the canonical MIPS NOP
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        ST_REQ     = 2'b00,  // requesting the word at pc
        ST_HOLD    = 2'b01,  // acked word parked while downstream stalls
        ST_SUSPEND = 2'b10   // instruction RAM being loaded
    } fetch_state_t;

    // Force an address onto a 32-bit word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register with hold and flush.
//   Priority: reset > flush > load > hold.
//
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset, clears everything
//   flush        in   insert a bubble (valid=0, instr=NOP)
//   load         in   capture load_instr / load_pc as a valid instruction
//   load_instr   in   instruction word to capture
//   load_pc      in   address of load_instr
//   if_valid     out  register holds a real instruction
//   if_instr     out  instruction (NOP when not valid)
//   if_pc        out  address of if_instr
//   if_pc_plus4  out  if_pc + 4
// -----------------------------------------------------------------------------
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            if_valid    <= 1'b0;
            if_instr    <= NOP_INSTR;
            if_pc       <= 32'h0;
            if_pc_plus4 <= 32'h0;
        end else if (flush) begin
            // The pc fields are left as-is; only valid/instr define a bubble.
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
        end else if (load) begin
            if_valid    <= 1'b1;
            if_instr    <= load_instr;
            if_pc       <= load_pc;
            if_pc_plus4 <= load_pc + PC_STEP;  // wraps modulo 2^32
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   MIPS instruction fetch: owns the PC, the REQ/HOLD/SUSPEND FSM and a
//   one-entry holding buffer for a word acked while downstream stalls.
//   The IF/ID register itself lives in if_id_reg.
//
//   clock           in   rising-edge clock
//   reset           in   synchronous active-high reset
//   fetch_ram_load  in   instruction RAM load in progress; fetch suspended
//   stall           in   downstream hazard; IF/ID held
//   branch_taken    in   redirect request from decode
//   branch_target   in   redirect address (low two bits ignored)
//   imem_req        out  instruction read request
//   imem_addr       out  word-aligned read address (= pc)
//   imem_ack        in   imem_rdata valid for imem_addr this cycle
//   imem_rdata      in   instruction word
//   if_valid        out  IF/ID holds a real instruction
//   if_instr        out  IF/ID instruction (NOP when invalid)
//   if_pc           out  address of if_instr
//   if_pc_plus4     out  if_pc + 4
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_ram_load,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  hold_instr;
    logic [31:0]  hold_pc;

    logic         ack_taken;
    logic         id_load;
    logic         id_flush;
    logic [31:0]  id_instr;
    logic [31:0]  id_pc;

    // imem_req is combinational so it drops in the very cycle reset or a
    // RAM load arrives, not one cycle later.
    assign imem_req  = (state == ST_REQ) && !reset && !fetch_ram_load;
    assign imem_addr = pc;

    // An ack only counts while a request is actually outstanding.
    assign ack_taken = imem_ack && imem_req;

    // IF/ID control. Reset is applied inside if_id_reg with top priority.
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        id_load  = 1'b0;
        id_flush = 1'b0;
        id_instr = hold_instr;
        id_pc    = hold_pc;
        if (fetch_ram_load) begin
            id_flush = 1'b1;
        end else begin
            unique case (state)
                ST_REQ: begin
                    if (branch_taken) begin
                        id_flush = 1'b1;
                    end else if (!stall) begin
                        if (ack_taken) begin
                            id_load  = 1'b1;
                            id_instr = imem_rdata;
                            id_pc    = pc;
                        end else begin
                            id_flush = 1'b1;  // no word this cycle: bubble
                        end
                    end
                end
                ST_HOLD: begin
                    if (branch_taken) begin
                        id_flush = 1'b1;
                    end else if (!stall) begin
                        id_load = 1'b1;  // drain the holding buffer
                    end
                end
                default: begin
                    id_flush = 1'b1;  // SUSPEND never presents a word
                end
            endcase
        end
    end

    // PC, FSM and holding buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_REQ;
            pc    <= RESET_PC;
            // NOTE: the holding buffer is a pair of plain registers, not a
            // RAM, so clearing it on reset is cheap and keeps outputs defined.
            hold_instr <= NOP_INSTR;
            hold_pc    <= 32'h0;
        end else if (fetch_ram_load) begin
            state <= ST_SUSPEND;
        end else begin
            unique case (state)
                ST_REQ: begin
                    if (branch_taken) begin
                        pc <= word_align(branch_target);
                    end else if (ack_taken) begin
                        pc <= pc + PC_STEP;  // wraps modulo 2^32
                        if (stall) begin
                            hold_instr <= imem_rdata;
                            hold_pc    <= pc;
                            state      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // pc already points past the held word.
                    if (branch_taken) begin
                        pc    <= word_align(branch_target);
                        state <= ST_REQ;
                    end else if (!stall) begin
                        state <= ST_REQ;
                    end
                end
                default: begin
                    // Reaching here means fetch_ram_load is already low.
                    pc    <= RESET_PC;
                    state <= ST_REQ;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clock       (clock),
        .reset       (reset),
        .flush       (id_flush),
        .load        (id_load),
        .load_instr  (id_instr),
        .load_pc     (id_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. Inputs change 1 ns after a rising edge;
//   outputs are sampled at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_ram_load;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int checks   = 0;
    int failures = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .fetch_ram_load (fetch_ram_load),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_ram_load = 1'b0;
        stall          = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req_during got=%b exp=0", imem_req); end
        cyc();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req_held got=%b exp=0", imem_req); end
        reset = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", if_instr); end
        checks++; if (if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin failures++; $display("FAIL reset_pcs got=%h/%h exp=0/0", if_pc, if_pc_plus4); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL reset_first_req got=%b@%h exp=1@0", imem_req, imem_addr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        words[0] = 32'h2001_0001;
        words[1] = 32'h2002_0002;
        words[2] = 32'h0022_1820;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = words[i];
            cyc();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== words[i] || if_pc_plus4 !== 32'(4 * i + 4)) begin
                failures++;
                $display("FAIL b2b_%0d got v=%b pc=%h instr=%h pc4=%h exp v=1 pc=%h instr=%h pc4=%h",
                         i, if_valid, if_pc, if_instr, if_pc_plus4, 32'(4 * i), words[i], 32'(4 * i + 4));
            end
        end
        checks++; if (imem_addr !== 32'hC) begin failures++; $display("FAIL b2b_next_addr got=%h exp=c", imem_addr); end
        // No ack, no stall: bubble, pc unchanged.
        imem_ack = 1'b0;
        cyc();
        checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || imem_addr !== 32'hC) begin failures++; $display("FAIL bubble got v=%b instr=%h addr=%h exp v=0 instr=0 addr=c", if_valid, if_instr, imem_addr); end
    endtask

    task automatic test_stall_hold();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_0000; cyc();
        imem_rdata = 32'hBBBB_0004; cyc();
        // Ack at pc 8 while stalled: goes to the buffer.
        stall = 1'b1; imem_rdata = 32'hCCCC_0008; cyc();
        imem_ack = 1'b0; imem_rdata = 32'h0;
        #1;
        checks++; if (if_pc !== 32'h4 || if_instr !== 32'hBBBB_0004 || if_valid !== 1'b1) begin failures++; $display("FAIL stall_keep1 got pc=%h instr=%h v=%b exp pc=4 instr=bbbb0004 v=1", if_pc, if_instr, if_valid); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_req1 got=%b exp=0", imem_req); end
        cyc();
        checks++; if (if_pc !== 32'h4 || if_instr !== 32'hBBBB_0004) begin failures++; $display("FAIL stall_keep2 got pc=%h instr=%h exp pc=4 instr=bbbb0004", if_pc, if_instr); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_req2 got=%b exp=0", imem_req); end
        stall = 1'b0;
        cyc();
        checks++; if (if_pc !== 32'h8 || if_instr !== 32'hCCCC_0008 || if_valid !== 1'b1) begin failures++; $display("FAIL hold_release got pc=%h instr=%h v=%b exp pc=8 instr=cccc0008 v=1", if_pc, if_instr, if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin failures++; $display("FAIL hold_resume got=%b@%h exp=1@c", imem_req, imem_addr); end
    endtask

    task automatic test_branch();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111; cyc();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0043;
        imem_rdata = 32'hDEAD_BEEF;
        cyc();
        stall = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin failures++; $display("FAIL branch_addr got=%b@%h exp=1@40", imem_req, imem_addr); end
        checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin failures++; $display("FAIL branch_flush got v=%b instr=%h exp v=0 instr=0", if_valid, if_instr); end
        imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
        cyc();
        checks++; if (if_pc !== 32'h40 || if_instr !== 32'h2222_2222 || if_valid !== 1'b1) begin failures++; $display("FAIL branch_fetch got pc=%h instr=%h v=%b exp pc=40 instr=22222222 v=1", if_pc, if_instr, if_valid); end
        // Branch out of HOLD also discards the buffered word.
        stall = 1'b1; imem_rdata = 32'h3333_3333; cyc();
        imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0100; cyc();
        branch_taken = 1'b0; stall = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin failures++; $display("FAIL branch_hold got v=%b req=%b addr=%h exp v=0 req=1 addr=100", if_valid, imem_req, imem_addr); end
    endtask

    task automatic test_ram_load();
        int bad_req = 0;
        int bad_valid = 0;
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h5555_0000; cyc();
        imem_rdata = 32'h5555_0004; cyc();
        fetch_ram_load = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (imem_req !== 1'b0) bad_req++;
            cyc();
            if (if_valid !== 1'b0) bad_valid++;
        end
        checks++; if (bad_req != 0) begin failures++; $display("FAIL ramload_req got=%0d high cycles exp=0", bad_req); end
        checks++; if (bad_valid != 0) begin failures++; $display("FAIL ramload_valid got=%0d valid cycles exp=0", bad_valid); end
        fetch_ram_load = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL suspend_exit_req got=%b exp=0", imem_req); end
        cyc();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL ramload_resume got=%b@%h exp=1@0", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h6666_0000; cyc();
        checks++; if (if_pc !== 32'h0 || if_instr !== 32'h6666_0000 || if_valid !== 1'b1) begin failures++; $display("FAIL ramload_first got pc=%h instr=%h v=%b exp pc=0 instr=66660000 v=1", if_pc, if_instr, if_valid); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE; cyc();
        branch_taken = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_align got=%h exp=fffffffc", imem_addr); end
        cyc();
        checks++; if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got pc=%h pc4=%h exp pc=fffffffc pc4=0", if_pc, if_pc_plus4); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got=%h exp=0", imem_addr); end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h8888_0000; cyc();
        stall = 1'b1; imem_rdata = 32'h8888_0004; cyc();   // now in HOLD
        imem_ack = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_reset_req_pre got=%b exp=0", imem_req); end
        cyc();
        checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin failures++; $display("FAIL hold_reset_out got v=%b instr=%h pc=%h pc4=%h exp all 0", if_valid, if_instr, if_pc, if_pc_plus4); end
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL hold_reset_req got=%b@%h exp=0@0", imem_req, imem_addr); end
        reset = 1'b0; stall = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL hold_reset_state got req=%b exp=1", imem_req); end
        // Stale buffer must not reappear.
        cyc();
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL hold_reset_buffer got v=%b exp=0", if_valid); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_stall_hold();
        test_branch();
        test_ram_load();
        test_pc_wrap();
        test_reset_in_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
